// File: rtl/sq_pkg.sv
// Shared types and state table for the squaring product collector.
// State s selects operand chunk pair (a,b); products land at column 32*(a+b).
package sq_pkg;

    localparam int SQ_NSTATES = 10;
    localparam int DIGIT_W    = 17;
    localparam int COL_W      = 48;

    typedef logic [COL_W-1:0] col_t;
    typedef logic [4:0]       sq_state_t;

    typedef struct packed {
        logic [7:0] base;
        logic       dbl;
    } base_dbl_t;

    // Column offset and doubling flag owned by each issued state.
    function automatic base_dbl_t sq_base_dbl(input logic [3:0] s);
        base_dbl_t r;
        r = '0;
        case (s)
            4'd1:    r = '{base: 8'd192, dbl: 1'b0};
            4'd2:    r = '{base: 8'd160, dbl: 1'b1};
            4'd3:    r = '{base: 8'd128, dbl: 1'b1};
            4'd4:    r = '{base: 8'd128, dbl: 1'b0};
            4'd5:    r = '{base: 8'd96,  dbl: 1'b1};
            4'd6:    r = '{base: 8'd96,  dbl: 1'b1};
            4'd7:    r = '{base: 8'd64,  dbl: 1'b1};
            4'd8:    r = '{base: 8'd64,  dbl: 1'b0};
            4'd9:    r = '{base: 8'd32,  dbl: 1'b1};
            4'd10:   r = '{base: 8'd0,   dbl: 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sq_tag_pipe.sv
// Tag shift register that follows each issued state through the
// multiplier pipe; the tail names the state whose products arrive now.
module sq_tag_pipe
    import sq_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [TW-1:0] head_i,
    output logic [TW-1:0] tail_o
);

    logic [TW-1:0] pipe_q [DEPTH];

    // Shift the head tag one stage per cycle; reset empties the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= head_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tail_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/sq_prod_collect.sv
// Squaring sequencer and redundant column accumulator.
// Optional single carry pass before done: define SQ_COLLECT_NORM_EN.
module sq_prod_collect
    import sq_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int NLANE   = 33,
    parameter int NCOL    = 258,
    parameter int ACC_W   = 48,
    parameter int PROD_W  = 43
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [4:0]              sq_state,
    input  logic [NLANE*PROD_W-1:0] prod_in,
    output logic [NCOL*ACC_W-1:0]   result
);

    localparam int CW = $clog2(NCOL);
    localparam int DW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
`ifdef SQ_COLLECT_NORM_EN
    localparam logic [2:0] S_NORM  = 3'd3;
`endif
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    sq_state_t        sqs_q, sqs_d;
    logic [DW-1:0]    drn_q, drn_d;
    logic             clr;
    logic             acc_en;
    logic             norm_en;
    logic [3:0]       tail;
    base_dbl_t        bd;
    logic [CW-1:0]    idx;
    logic [ACC_W-1:0] col_q [NCOL];
    logic [ACC_W-1:0] col_d [NCOL];

    sq_tag_pipe #(
        .DEPTH (MUL_LAT),
        .TW    (4)
    ) u_tags (
        .clk    (clk),
        .rst_n  (rst_n),
        .head_i (sqs_q[3:0]),
        .tail_o (tail)
    );

    // Sequencer: issue states 1..N, drain the multiplier pipe, finish.
    always_comb begin
        state_d = state_q;
        sqs_d   = sqs_q;
        drn_d   = drn_q;
        clr     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    sqs_d   = 5'd1;
                    clr     = 1'b1;
                end
            end
            S_ISSUE: begin
                if (sqs_q == 5'(SQ_NSTATES)) begin
                    state_d = S_DRAIN;
                    sqs_d   = '0;
                    drn_d   = '0;
                end else begin
                    sqs_d = sqs_q + 5'd1;
                end
            end
            S_DRAIN: begin
                drn_d = drn_q + DW'(1);
                if (drn_q == DW'(MUL_LAT - 1)) begin
`ifdef SQ_COLLECT_NORM_EN
                    state_d = S_NORM;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef SQ_COLLECT_NORM_EN
            S_NORM:  state_d = S_DONE;
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sqs_q   <= '0;
            drn_q   <= '0;
        end else begin
            state_q <= state_d;
            sqs_q   <= sqs_d;
            drn_q   <= drn_d;
        end
    end

    assign acc_en = (tail != 4'd0);
`ifdef SQ_COLLECT_NORM_EN
    assign norm_en = (state_q == S_NORM);
`else
    assign norm_en = 1'b0;
`endif

    // Column update: clear on start, add returning lanes, or carry pass.
    always_comb begin
        col_d = col_q;
        bd    = sq_base_dbl(tail);
        idx   = '0;
        unique case (1'b1)
            clr: begin
                col_d = '{default: '0};
            end
            acc_en: begin
                for (int j = 0; j < NLANE; j++) begin
                    idx = CW'(bd.base) + CW'(j);
                    col_d[idx] = col_q[idx]
                        + (ACC_W'(prod_in[j*PROD_W +: PROD_W]) << bd.dbl);
                end
            end
            norm_en: begin
                col_d[0] = ACC_W'(col_q[0][DIGIT_W-1:0]);
                for (int c = 1; c < NCOL; c++) begin
                    col_d[c] = ACC_W'(col_q[c][DIGIT_W-1:0])
                        + ACC_W'(col_q[c-1][ACC_W-1:DIGIT_W]);
                end
            end
            default: ;
        endcase
    end

    // Accumulator columns; hold between operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '{default: '0};
        end else begin
            col_q <= col_d;
        end
    end

    for (genvar c = 0; c < NCOL; c++) begin : g_res
        assign result[c*ACC_W +: ACC_W] = col_q[c];
    end

    assign sq_state = sqs_q;
    assign done     = (state_q == S_DONE);
    assign busy     = (state_q == S_ISSUE) || (state_q == S_DRAIN)
                    || norm_en;

endmodule

// File: tb/tb_sq_prod_collect.sv
// Scoreboard bench for sq_prod_collect: random and directed squarings
// checked against a column-arithmetic reference model.
module tb_sq_prod_collect;

    localparam int MUL_LAT = 2;
    localparam int NLANE   = 33;
    localparam int NCOL    = 258;
    localparam int ACC_W   = 48;
    localparam int PROD_W  = 43;
    localparam int PW      = NLANE * PROD_W;
    localparam int RW      = NCOL * ACC_W;
`ifdef SQ_COLLECT_NORM_EN
    localparam int DONE_CYC = 12 + MUL_LAT;
`else
    localparam int DONE_CYC = 11 + MUL_LAT;
`endif

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic [4:0]    sq_state;
    logic [PW-1:0] prod_in;
    logic [RW-1:0] result;

    sq_prod_collect #(
        .MUL_LAT (MUL_LAT),
        .NLANE   (NLANE),
        .NCOL    (NCOL),
        .ACC_W   (ACC_W),
        .PROD_W  (PROD_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .sq_state (sq_state),
        .prod_in  (prod_in),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int n_done = 0;
    int n_runs = 0;

    logic [PROD_W-1:0] pv [1:10][NLANE];
    logic [RW-1:0]     exp_q [$];

    task automatic chk(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: sum every state's products into columns 32*(a+b)+lane.
    function automatic logic [RW-1:0] model();
        longint unsigned col [NCOL];
        longint unsigned old [NCOL];
        longint unsigned mask;
        int a_tab [10] = '{3, 3, 3, 2, 3, 2, 2, 1, 1, 0};
        int b_tab [10] = '{3, 2, 1, 2, 0, 1, 0, 1, 0, 0};
        logic [RW-1:0] r;
        mask = (64'd1 << ACC_W) - 1;
        for (int c = 0; c < NCOL; c++) col[c] = 0;
        for (int s = 1; s <= 10; s++) begin
            int a, b, base;
            a = a_tab[s-1];
            b = b_tab[s-1];
            base = 32 * (a + b);
            for (int j = 0; j < NLANE; j++) begin
                longint unsigned p;
                p = longint'(pv[s][j]);
                if (a != b) p = p * 2;
                col[base+j] = (col[base+j] + p) & mask;
            end
        end
`ifdef SQ_COLLECT_NORM_EN
        for (int c = 0; c < NCOL; c++) old[c] = col[c];
        for (int c = 0; c < NCOL; c++) begin
            col[c] = old[c] % 131072;
            if (c > 0) col[c] = (col[c] + old[c-1] / 131072) & mask;
        end
`else
        for (int c = 0; c < NCOL; c++) old[c] = col[c];
`endif
        r = '0;
        for (int c = 0; c < NCOL; c++) r[c*ACC_W +: ACC_W] = old[c][ACC_W-1:0] & 48'hFFFF_FFFF_FFFF | col[c][ACC_W-1:0];
        for (int c = 0; c < NCOL; c++) r[c*ACC_W +: ACC_W] = col[c][ACC_W-1:0];
        return r;
    endfunction

    function automatic logic [PW-1:0] pack(input int s);
        logic [PW-1:0] v;
        for (int j = 0; j < NLANE; j++) v[j*PROD_W +: PROD_W] = pv[s][j];
        return v;
    endfunction

    function automatic logic [PW-1:0] garbage();
        logic [PW-1:0] v;
        logic [63:0] w;
        for (int j = 0; j < NLANE; j++) begin
            w = {$urandom(), $urandom()};
            v[j*PROD_W +: PROD_W] = w[PROD_W-1:0];
        end
        return v;
    endfunction

    task automatic clear_pv();
        for (int s = 1; s <= 10; s++)
            for (int j = 0; j < NLANE; j++) pv[s][j] = '0;
    endtask

    task automatic rand_pv();
        logic [63:0] w;
        for (int s = 1; s <= 10; s++)
            for (int j = 0; j < NLANE; j++) begin
                w = {$urandom(), $urandom()};
                pv[s][j] = ($urandom_range(0, 3) == 0) ? '0 : w[PROD_W-1:0];
            end
    endtask

    // Monitor: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            logic [RW-1:0] e;
            n_done++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL result: done with no expected result queued");
            end else begin
                e = exp_q.pop_front();
                if (result !== e) begin
                    int c;
                    n_bad++;
                    c = 0;
                    while (c < NCOL - 1 && result[c*ACC_W +: ACC_W] === e[c*ACC_W +: ACC_W]) c++;
                    $display("FAIL result: col %0d got %0h expected %0h",
                             c, result[c*ACC_W +: ACC_W], e[c*ACC_W +: ACC_W]);
                end
            end
        end
    end

    // One squaring with cycle-exact sequencing checks.
    task automatic run_op(input bit abort6, input bit poke4, input bit rnd_start);
        @(posedge clk);
        #1;
        start = 1'b1;
        prod_in = garbage();
        if (!abort6) begin
            exp_q.push_back(model());
            n_runs++;
        end
        for (int n = 1; n <= DONE_CYC; n++) begin
            int k;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (poke4 && n == 4) start = 1'b1;
            if (rnd_start && n < DONE_CYC) start = 1'($urandom_range(0, 1));
            k = n - MUL_LAT;
            prod_in = (k >= 1 && k <= 10) ? pack(k) : garbage();
            if (abort6 && n == 6) begin
                rst_n = 1'b0;
                start = 1'b0;
                @(negedge clk);
                chk("abort_busy", longint'(busy), 0);
                chk("abort_done", longint'(done), 0);
                chk("abort_sq_state", longint'(sq_state), 0);
                n_vec++;
                if (result !== '0) begin
                    n_bad++;
                    $display("FAIL abort_result: got nonzero expected 0");
                end
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            chk($sformatf("sq_state_c%0d", n), longint'(sq_state), (n <= 10) ? n : 0);
            chk($sformatf("busy_c%0d", n), longint'(busy), (n < DONE_CYC) ? 1 : 0);
            chk($sformatf("done_c%0d", n), longint'(done), (n == DONE_CYC) ? 1 : 0);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        prod_in = garbage();
        @(negedge clk);
        chk("idle_done", longint'(done), 0);
        chk("idle_busy", longint'(busy), 0);
        chk("idle_sq_state", longint'(sq_state), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        prod_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_sq_state", longint'(sq_state), 0);
        n_vec++;
        if (result !== '0) begin
            n_bad++;
            $display("FAIL rst_result: got nonzero expected 0");
        end
        rst_n = 1'b1;

        clear_pv();
        for (int j = 0; j < NLANE; j++) pv[1][j] = 43'd1;
        run_op(0, 0, 0);
        chk("dir1_col192", longint'(result[192*ACC_W +: ACC_W]), 1);

        clear_pv();
        pv[2][0] = 43'd5;
        run_op(0, 0, 0);
        chk("dir2_col160", longint'(result[160*ACC_W +: ACC_W]), 10);

        clear_pv();
        pv[3][0] = 43'd7;
        pv[4][0] = 43'd7;
        run_op(0, 0, 0);
        chk("dir3_col128", longint'(result[128*ACC_W +: ACC_W]), 21);

        clear_pv();
        pv[10][0] = 43'h2_0003;
        run_op(0, 0, 0);
`ifdef SQ_COLLECT_NORM_EN
        chk("dir4_col0", longint'(result[0 +: ACC_W]), 3);
        chk("dir4_col1", longint'(result[ACC_W +: ACC_W]), 1);
`else
        chk("dir4_col0", longint'(result[0 +: ACC_W]), 64'h2_0003);
`endif

        rand_pv();
        run_op(1, 0, 0);
        rand_pv();
        run_op(0, 0, 0);

        rand_pv();
        run_op(0, 1, 0);

        for (int r = 0; r < 6; r++) begin
            rand_pv();
            run_op(0, 0, 1);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pending_expect", longint'(exp_q.size()), 0);
        chk("done_count", longint'(n_done), longint'(n_runs));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
